// File: rtl/lsu_bus_master_if.sv
// Request, response and data-bus controller signals of the load/store unit.
// The master modport is the LSU's view; slave is the CPU/controller side.
interface lsu_bus_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        bus_rd;
   logic        bus_wd;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr_in;
   logic [31:0] bus_addr_out;
   logic [31:0] bus_data_in;
   logic [31:0] bus_data_out;
   logic        bus_ready;
   logic        bus_busy;

   modport master (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
             bus_data_out, bus_ready, bus_busy,
      output req_ready, resp_valid, resp_rdata, resp_err,
             bus_rd, bus_wd, bus_size, bus_addr_in, bus_addr_out, bus_data_in
   );

   modport slave (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
             bus_data_out, bus_ready, bus_busy,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             bus_rd, bus_wd, bus_size, bus_addr_in, bus_addr_out, bus_data_in
   );
endinterface

// File: rtl/lsu_bus_master.sv
// RV32I load/store unit: one request at a time, decode/align check, single-cycle
// bus strobe with timeout, extended load data returned over a valid/ready response.
module lsu_bus_master #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input logic              clk,
   input logic              rst,
   lsu_bus_master_if.master lsu
);
   localparam logic [1:0] ERR_OK       = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t            state;
   logic              we;
   logic [2:0]        funct3;
   logic [CNT_W-1:0]  cnt;

   logic              bus_free_c;
   logic              strobe_c;
   logic              req_illegal_c;
   logic              req_misalign_c;
   logic [31:0]       load_ext_c;

   // Strobe is combinational so the transfer happens in the first free cycle;
   // gated by rst so an abandoned transaction never reaches the controller.
   assign bus_free_c = lsu.bus_ready && !lsu.bus_busy;
   assign strobe_c   = rst && (state == ISSUE) && bus_free_c;
   assign lsu.bus_rd = strobe_c && !we;
   assign lsu.bus_wd = strobe_c && we;

   always_comb begin
      req_illegal_c  = 1'b1;
      req_misalign_c = 1'b0;
      case (lsu.req_funct3)
         3'b000, 3'b001, 3'b010: req_illegal_c = 1'b0;
         3'b100, 3'b101:         req_illegal_c = lsu.req_we;
         default:                req_illegal_c = 1'b1;
      endcase
      case (lsu.req_funct3[1:0])
         2'b01:   req_misalign_c = lsu.req_addr[0];
         2'b10:   req_misalign_c = (lsu.req_addr[1:0] != 2'b00);
         default: req_misalign_c = 1'b0;
      endcase
   end

   always_comb begin
      load_ext_c = lsu.bus_data_out;
      case (funct3)
         3'b000:  load_ext_c = {{24{lsu.bus_data_out[7]}},  lsu.bus_data_out[7:0]};
         3'b100:  load_ext_c = {24'd0,                      lsu.bus_data_out[7:0]};
         3'b001:  load_ext_c = {{16{lsu.bus_data_out[15]}}, lsu.bus_data_out[15:0]};
         3'b101:  load_ext_c = {16'd0,                      lsu.bus_data_out[15:0]};
         default: load_ext_c = lsu.bus_data_out;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state            <= IDLE;
         we               <= 1'b0;
         funct3           <= 3'd0;
         cnt              <= '0;
         lsu.req_ready    <= 1'b1;
         lsu.resp_valid   <= 1'b0;
         lsu.resp_rdata   <= 32'd0;
         lsu.resp_err     <= ERR_OK;
         lsu.bus_size     <= 2'd0;
         lsu.bus_addr_in  <= 32'd0;
         lsu.bus_addr_out <= 32'd0;
         lsu.bus_data_in  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (lsu.req_valid) begin
                  we            <= lsu.req_we;
                  funct3        <= lsu.req_funct3;
                  lsu.req_ready <= 1'b0;
                  if (req_illegal_c || req_misalign_c) begin
                     state          <= RESP;
                     lsu.resp_valid <= 1'b1;
                     lsu.resp_rdata <= 32'd0;
                     lsu.resp_err   <= req_illegal_c ? ERR_ILLEGAL : ERR_MISALIGN;
                  end else begin
                     state            <= ISSUE;
                     cnt              <= '0;
                     lsu.bus_size     <= lsu.req_funct3[1:0];
                     lsu.bus_addr_in  <= lsu.req_addr;
                     lsu.bus_addr_out <= lsu.req_addr;
                     lsu.bus_data_in  <= lsu.req_wdata;
                  end
               end
            end
            ISSUE: begin
               if (bus_free_c) begin
                  state          <= RESP;
                  lsu.resp_valid <= 1'b1;
                  lsu.resp_err   <= ERR_OK;
                  lsu.resp_rdata <= we ? 32'd0 : load_ext_c;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  state          <= RESP;
                  lsu.resp_valid <= 1'b1;
                  lsu.resp_err   <= ERR_TIMEOUT;
                  lsu.resp_rdata <= 32'd0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (lsu.resp_ready) begin
                  state          <= IDLE;
                  lsu.resp_valid <= 1'b0;
                  lsu.resp_rdata <= 32'd0;
                  lsu.resp_err   <= ERR_OK;
                  lsu.req_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: directed and random transactions, expectations laid
// out per cycle from a transaction-level model and checked by one compare process.
module tb_lsu_bus_master;
   localparam int TIMEOUT = 16;
   localparam int MAXC    = 16384;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lsu_bus_master_if lif();

   lsu_bus_master #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .lsu (lif.master)
   );

   typedef struct {
      bit        valid, rr, rv, rd, wd, chk_bus, chk_resp, chk_zero, is_store;
      bit [1:0]  size, err;
      bit [31:0] addr, wdata, rdata;
   } exp_t;

   typedef struct {
      bit        we;
      bit [2:0]  f3;
      bit [31:0] addr, wdata;
      bit        fix_data;
      bit [31:0] bdata;
      int        busy_n, hold, gap, rst_at;
      bit        lit;
      bit [31:0] lit_rdata;
      bit [1:0]  lit_err;
   } txn_t;

   exp_t ex [MAXC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, expv);
      end
   endtask

   // Single compare process: every cycle that carries an expectation.
   always @(negedge clk) begin
      if (cyc < MAXC && ex[cyc].valid) begin
         chk("req_ready",  32'(lif.req_ready),  32'(ex[cyc].rr));
         chk("resp_valid", 32'(lif.resp_valid), 32'(ex[cyc].rv));
         chk("bus_rd",     32'(lif.bus_rd),     32'(ex[cyc].rd));
         chk("bus_wd",     32'(lif.bus_wd),     32'(ex[cyc].wd));
         if (ex[cyc].chk_bus) begin
            chk("bus_size",     32'(lif.bus_size), 32'(ex[cyc].size));
            chk("bus_addr_out", lif.bus_addr_out,  ex[cyc].addr);
            chk("bus_addr_in",  lif.bus_addr_in,   ex[cyc].addr);
            if (ex[cyc].is_store) chk("bus_data_in", lif.bus_data_in, ex[cyc].wdata);
         end
         if (ex[cyc].chk_resp) begin
            chk("resp_rdata", lif.resp_rdata,      ex[cyc].rdata);
            chk("resp_err",   32'(lif.resp_err),   32'(ex[cyc].err));
         end
         if (ex[cyc].chk_zero) begin
            chk("rst_rdata",    lif.resp_rdata,      32'd0);
            chk("rst_err",      32'(lif.resp_err),   32'd0);
            chk("rst_size",     32'(lif.bus_size),   32'd0);
            chk("rst_addr_in",  lif.bus_addr_in,     32'd0);
            chk("rst_addr_out", lif.bus_addr_out,    32'd0);
            chk("rst_data_in",  lif.bus_data_in,     32'd0);
         end
      end
   end

   // Model: error classification straight from the RV32I load/store rules.
   function automatic bit [1:0] model_err(input bit we, input bit [2:0] f3, input bit [31:0] addr);
      int bytes;
      bit legal;
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
              (!we && (f3 == 3'd4 || f3 == 3'd5));
      if (!legal) return 2'd2;
      bytes = 1 << (int'(f3) % 4);
      if ((int'(addr[1:0]) % bytes) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit [31:0] model_load(input bit [2:0] f3, input bit [31:0] d);
      int v;
      case (f3)
         3'd0: begin v = int'(d[7:0]);  if (v > 127)   v -= 256;   end
         3'd4:       v = int'(d[7:0]);
         3'd1: begin v = int'(d[15:0]); if (v > 32767) v -= 65536; end
         3'd5:       v = int'(d[15:0]);
         default:    v = int'(d);
      endcase
      return 32'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input bit rr, input bit rv, input bit rd, input bit wd);
      if (cyc < MAXC) begin
         ex[cyc]       = '{default: 0};
         ex[cyc].valid = 1'b1;
         ex[cyc].rr    = rr;
         ex[cyc].rv    = rv;
         ex[cyc].rd    = rd;
         ex[cyc].wd    = wd;
      end
   endtask

   task automatic rand_bus();
      lif.bus_ready    = 1'($urandom_range(0, 1));
      lif.bus_busy     = 1'($urandom_range(0, 1));
      lif.bus_data_out = $urandom;
      lif.resp_ready   = 1'($urandom_range(0, 1));
   endtask

   task automatic make_unavail();
      case ($urandom_range(0, 2))
         0:       begin lif.bus_ready = 1'b0; lif.bus_busy = 1'b0; end
         1:       begin lif.bus_ready = 1'b0; lif.bus_busy = 1'b1; end
         default: begin lif.bus_ready = 1'b1; lif.bus_busy = 1'b1; end
      endcase
   endtask

   task automatic garbage_req();
      lif.req_valid  = 1'($urandom_range(0, 1));
      lif.req_we     = 1'($urandom_range(0, 1));
      lif.req_funct3 = 3'($urandom_range(0, 7));
      lif.req_addr   = $urandom;
      lif.req_wdata  = $urandom;
   endtask

   task automatic run_txn(input txn_t t);
      bit [1:0]  err;
      bit [31:0] rdata;
      bit        avail;
      for (int i = 0; i < t.gap; i++) begin
         tick(); lif.req_valid = 1'b0; rand_bus(); set_exp(1, 0, 0, 0);
      end
      tick();
      lif.req_valid  = 1'b1;
      lif.req_we     = t.we;
      lif.req_funct3 = t.f3;
      lif.req_addr   = t.addr;
      lif.req_wdata  = t.wdata;
      rand_bus();
      set_exp(1, 0, 0, 0);
      err   = model_err(t.we, t.f3, t.addr);
      rdata = 32'd0;
      if (err == 2'd0) begin
         for (int k = 0; k < TIMEOUT; k++) begin
            tick(); garbage_req(); rand_bus();
            avail = (k >= t.busy_n);
            if (avail) begin lif.bus_ready = 1'b1; lif.bus_busy = 1'b0; end
            else make_unavail();
            if (t.fix_data) lif.bus_data_out = t.bdata;
            if (t.rst_at == k) begin
               rst = 1'b0; set_exp(0, 0, 0, 0);
               tick(); rst = 1'b1; lif.req_valid = 1'b0; rand_bus();
               set_exp(1, 0, 0, 0);
               if (cyc < MAXC) ex[cyc].chk_zero = 1'b1;
               return;
            end
            set_exp(0, 0, avail && !t.we, avail && t.we);
            if (avail) begin
               if (cyc < MAXC) begin
                  ex[cyc].chk_bus  = 1'b1;
                  ex[cyc].is_store = t.we;
                  ex[cyc].size     = t.f3[1:0];
                  ex[cyc].addr     = t.addr;
                  ex[cyc].wdata    = t.wdata;
               end
               rdata = t.we ? 32'd0 : model_load(t.f3, lif.bus_data_out);
               break;
            end
            if (k == TIMEOUT - 1) err = 2'd3;
         end
      end
      if (t.lit) begin
         chk("model_err_pin",   32'(err), 32'(t.lit_err));
         chk("model_rdata_pin", rdata,    t.lit_rdata);
      end
      for (int j = 0; j <= t.hold; j++) begin
         tick(); garbage_req(); rand_bus();
         lif.resp_ready = (j == t.hold);
         set_exp(0, 1, 0, 0);
         if (cyc < MAXC) begin
            ex[cyc].chk_resp = 1'b1;
            ex[cyc].rdata    = rdata;
            ex[cyc].err      = err;
         end
      end
   endtask

   function automatic txn_t mk(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                               input bit [31:0] wdata, input bit [31:0] bdata,
                               input int busy_n, input int hold, input int rst_at,
                               input bit [31:0] lit_rdata, input bit [1:0] lit_err);
      txn_t t;
      t.we = we; t.f3 = f3; t.addr = addr; t.wdata = wdata;
      t.fix_data = 1'b1; t.bdata = bdata;
      t.busy_n = busy_n; t.hold = hold; t.gap = 1; t.rst_at = rst_at;
      t.lit = (rst_at < 0); t.lit_rdata = lit_rdata; t.lit_err = lit_err;
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      txn_t t;
      int   r;
      lif.req_valid = 1'b1; lif.req_we = 1'b0; lif.req_funct3 = 3'd2;
      lif.req_addr = 32'h100; lif.req_wdata = 32'd0;
      rand_bus();
      // Reset held with a pending request: reset must win.
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) begin rst = 1'b1; lif.req_valid = 1'b0; end
         rand_bus();
         set_exp(1, 0, 0, 0);
         ex[cyc].chk_zero = 1'b1;
      end

      run_txn(mk(0, 3'd0, 32'h10, 32'h0,        32'h000000F0, 0,  0, -1, 32'hFFFFFFF0, 2'd0));
      run_txn(mk(0, 3'd4, 32'h10, 32'h0,        32'h000000F0, 0,  0, -1, 32'h000000F0, 2'd0));
      run_txn(mk(0, 3'd5, 32'h12, 32'h0,        32'h12348001, 0,  1, -1, 32'h00008001, 2'd0));
      run_txn(mk(0, 3'd2, 32'h14, 32'h0,        32'h12348001, 0,  0, -1, 32'h12348001, 2'd0));
      run_txn(mk(1, 3'd1, 32'h20, 32'hDEADBEEF, 32'h55555555, 0,  0, -1, 32'h0,        2'd0));
      run_txn(mk(0, 3'd2, 32'h22, 32'h0,        32'h0,        0,  0, -1, 32'h0,        2'd1));
      run_txn(mk(1, 3'd1, 32'h21, 32'h1234,     32'h0,        0,  0, -1, 32'h0,        2'd1));
      run_txn(mk(0, 3'd3, 32'h40, 32'h0,        32'h0,        0,  0, -1, 32'h0,        2'd2));
      run_txn(mk(1, 3'd4, 32'h40, 32'h0,        32'h0,        0,  0, -1, 32'h0,        2'd2));
      run_txn(mk(0, 3'd2, 32'h30, 32'h0,        32'hCAFEF00D, 5,  0, -1, 32'hCAFEF00D, 2'd0));
      run_txn(mk(1, 3'd2, 32'h40, 32'h11223344, 32'h0,        99, 0, -1, 32'h0,        2'd3));
      run_txn(mk(0, 3'd1, 32'h50, 32'h0,        32'h00008001, 15, 4, -1, 32'hFFFF8001, 2'd0));
      run_txn(mk(0, 3'd2, 32'h60, 32'h0,        32'h0,        99, 0, 2,  32'h0,        2'd0));

      for (int n = 0; n < 250; n++) begin
         t.we = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r < 8) t.f3 = t.we ? 3'($urandom_range(0, 2))
                                : ((r < 4) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
         else       t.f3 = 3'($urandom_range(0, 7));
         t.addr     = $urandom;
         if ($urandom_range(0, 1) == 0) t.addr[1:0] = 2'b00;
         t.wdata    = $urandom;
         t.fix_data = 1'b0;
         t.bdata    = 32'd0;
         r = $urandom_range(0, 19);
         if (r < 10)      t.busy_n = 0;
         else if (r < 18) t.busy_n = $urandom_range(1, 6);
         else if (r == 18) t.busy_n = TIMEOUT - 1;
         else             t.busy_n = 99;
         t.hold   = $urandom_range(0, 4);
         t.gap    = $urandom_range(0, 2);
         t.rst_at = -1;
         if (t.busy_n >= 3 && $urandom_range(0, 9) == 0)
            t.rst_at = $urandom_range(0, ((t.busy_n > TIMEOUT) ? TIMEOUT : t.busy_n) - 1);
         t.lit = 1'b0; t.lit_rdata = 32'd0; t.lit_err = 2'd0;
         run_txn(t);
      end

      for (int i = 0; i < 3; i++) begin
         tick(); lif.req_valid = 1'b0; rand_bus(); set_exp(1, 0, 0, 0);
      end
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Load/store unit between the CPU execute stage and the data bus controller.
- Accepts one RV32I load/store request at a time over a valid/ready handshake.
- Decodes funct3 into bus size, rejects misaligned or illegal accesses without touching the bus, and drives the controller's rd/wd/size/addr/data strobes.
- Returns sign- or zero-extended load data, or an error code, over a valid/ready response channel.

Parameters:
- TIMEOUT, 16, cycles ISSUE may wait for bus_ready && !bus_busy before aborting; must be ≥1.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset
- req_valid  input  1  CPU request valid
- req_ready  output  1  LSU can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response valid
- resp_ready  input  1  CPU consumes response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  2  0 ok, 1 misaligned, 2 illegal funct3, 3 timeout
- bus_rd  output  1  read strobe to controller
- bus_wd  output  1  write strobe to controller
- bus_size  output  2  00 byte, 01 half, 10 word
- bus_addr_in  output  32  write address
- bus_addr_out  output  32  read address
- bus_data_in  output  32  write data
- bus_data_out  input  32  read data from controller, valid combinationally while bus_rd is high
- bus_ready  input  1  controller ready
- bus_busy  input  1  controller busy

Behaviour:
- **Reset** (rst low at a clk edge):
  - State = IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - bus_rd=0, bus_wd=0, bus_size=0, bus addresses and bus_data_in = 0, counter=0.
  - Reset mid-transaction abandons it; no response is produced.
- **States:** IDLE, ISSUE, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid, register we, funct3, addr and wdata.
  - Decode:
    - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Stores: 000 SB, 001 SH, 010 SW.
    - Any other funct3 is illegal and sets err=2.
  - Alignment (checked only if funct3 is legal): half requires addr[0]=0; word requires addr[1:0]=00. Failure sets err=1.
  - On error, go to RESP with rdata=0 and no bus strobe ever asserted.
  - Otherwise go to ISSUE with counter=0.
- **req_ready** is 0 in ISSUE and RESP, so the LSU has a single outstanding request.
- **ISSUE:**
  - bus_size, both bus addresses and bus_data_in are driven from the registered request. Stores drive bus_data_in = wdata unmodified.
  - The strobe (bus_rd for loads, bus_wd for stores) is asserted combinationally only when bus_ready && !bus_busy.
  - In that cycle, loads capture bus_data_out and extend it:
    - LB: sign-extend bit 7.
    - LBU: zero-extend bits [7:0].
    - LH: sign-extend bit 15.
    - LHU: zero-extend bits [15:0].
    - LW: pass through.
  - Then go to RESP with err=0. Stores go to RESP with rdata=0.
  - If the bus is not available, increment the counter. When counter == TIMEOUT-1 and the bus is still unavailable, go to RESP with err=3, rdata=0, and no strobe issued.
  - The strobe is high for exactly one cycle per transaction.
- **RESP:**
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready, go to IDLE; resp_valid drops the next cycle.
  - A new request is accepted no earlier than the cycle after returning to IDLE (no bypass).
- **Latency** with the bus free: accept at edge T, strobe during cycle T+1, resp_valid high from T+2. Minimum 3 cycles per request.
- **Simultaneous events:** in IDLE, req_valid together with reset means reset wins.

Test Plan:
- **LB load:** bus_data_out=0x000000F0, LB addr 0x10 → one bus_rd pulse with bus_size=00 and bus_addr_out=0x10; resp_rdata=0xFFFFFFF0, err=0, resp_valid at T+2.
- **LBU / LHU / LW:** same data with LBU → 0x000000F0. Data 0x12348001: LHU → 0x00008001, LW → 0x12348001.
- **SH store:** addr 0x20, wdata 0xDEADBEEF → bus_wd for one cycle, bus_size=01, bus_addr_in=0x20, bus_data_in=0xDEADBEEF; resp err=0, rdata=0.
- **Misaligned / illegal:** LW at 0x22 → err=1; SH at 0x21 → err=1; funct3=011 load → err=2; in all cases bus_rd and bus_wd never assert.
- **Busy bus:** bus_busy=1 for 5 cycles then 0 → strobe issued in the first free cycle, err=0. bus_busy held high with TIMEOUT=16 → err=3 after 16 ISSUE cycles, no strobe.
- **Back-pressure and reset:** resp_ready held low for 4 cycles → outputs stable and req_ready=0 throughout. rst low during ISSUE → next cycle IDLE, all outputs at reset values, no resp_valid.
